// File: rtl/ibex_bloom_pkg.sv
// Shared types and hash constants for the custom-instruction Bloom filter.
// Operation and state encodings plus the multiplicative hash table.
package ibex_bloom_pkg;

    typedef enum logic [1:0] {
        BLOOM_INSERT  = 2'b00,
        BLOOM_CHECK   = 2'b01,
        BLOOM_CLEAR   = 2'b10,
        BLOOM_ILLEGAL = 2'b11
    } bloom_op_e;

    typedef enum logic [1:0] {
        IDLE,
        HASH,
        CLEAR,
        RESP
    } bloom_state_e;

    localparam logic [31:0] HASH_MULT [4] = '{
        32'h9E3779B1,
        32'h85EBCA77,
        32'hC2B2AE3D,
        32'h27D4EB2F
    };

endpackage

// File: rtl/ibex_bloom_hash.sv
// Combinational multiplicative hash: the key is scaled by HASH_MULT[k] mod 2^32
// and the top IdxWidth bits of the product form the bit-array index.
module ibex_bloom_hash
    import ibex_bloom_pkg::*;
#(
    parameter int KeyWidth = 32,
    parameter int NumBits  = 256,
    parameter int IdxWidth = $clog2(NumBits)
) (
    input  logic [KeyWidth-1:0] key,
    input  logic [1:0]          k,
    output logic [IdxWidth-1:0] idx
);

    logic [31:0] key_ext;
    logic [31:0] product;

    assign key_ext = 32'(key);
    assign product = key_ext * HASH_MULT[k];
    // Shift rather than slice so the discarded low product bits stay quiet in lint.
    assign idx     = IdxWidth'(product >> (32 - IdxWidth));

endmodule

// File: rtl/ibex_bloom_filter.sv
// Bloom-filter responder for the custom-instruction interface: multi-cycle
// INSERT/CHECK (one hash per cycle), word-wise CLEAR sweep, single outstanding request.
module ibex_bloom_filter
    import ibex_bloom_pkg::*;
#(
    parameter int KeyWidth  = 32,
    parameter int NumBits   = 256,
    parameter int NumHashes = 3,
    parameter int WordWidth = 32,
    parameter int CntWidth  = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_op_i,
    input  logic [KeyWidth-1:0] req_key_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic                rsp_match_o,
    output logic                rsp_err_o,
    output logic                busy_o,
    output logic [CntWidth-1:0] count_o
);

    localparam int IdxWidth  = $clog2(NumBits);
    localparam int NumWords  = NumBits / WordWidth;
    localparam int StepWidth = (NumWords > 4) ? $clog2(NumWords) : 2;

    bloom_state_e          state_reg, state_next;
    bloom_op_e             op_reg;
    bloom_op_e             req_op;
    logic [KeyWidth-1:0]   key_reg;
    logic [StepWidth-1:0]  step_reg;
    logic [NumBits-1:0]    bits_reg;
    logic                  match_reg;
    logic                  err_reg;
    logic [CntWidth-1:0]   count_reg;
    logic [IdxWidth-1:0]   hash_idx;
    logic [IdxWidth-1:0]   word_base;
    logic                  last_hash;
    logic                  last_word;

    assign req_op    = bloom_op_e'(req_op_i);
    assign last_hash = (step_reg == StepWidth'(NumHashes - 1));
    assign last_word = (step_reg == StepWidth'(NumWords - 1));
    assign word_base = IdxWidth'(int'(step_reg) * WordWidth);

    ibex_bloom_hash #(
        .KeyWidth (KeyWidth),
        .NumBits  (NumBits),
        .IdxWidth (IdxWidth)
    ) u_hash (
        .key (key_reg),
        .k   (step_reg[1:0]),
        .idx (hash_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid_i) begin
                    case (req_op)
                        BLOOM_INSERT, BLOOM_CHECK: state_next = HASH;
                        BLOOM_CLEAR:               state_next = CLEAR;
                        default:                   state_next = RESP;
                    endcase
                end
            end
            HASH:    if (last_hash)   state_next = RESP;
            CLEAR:   if (last_word)   state_next = RESP;
            RESP:    if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reading a bit already set earlier in the same INSERT cannot change the
    // AND, so the accumulator always reflects the array as it was before the op.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_reg    <= BLOOM_INSERT;
            key_reg   <= '0;
            step_reg  <= '0;
            bits_reg  <= '0;
            match_reg <= 1'b0;
            err_reg   <= 1'b0;
            count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    step_reg <= '0;
                    if (req_valid_i) begin
                        op_reg    <= req_op;
                        key_reg   <= req_key_i;
                        match_reg <= (req_op == BLOOM_INSERT) || (req_op == BLOOM_CHECK);
                        err_reg   <= (req_op == BLOOM_ILLEGAL);
                        if (req_op == BLOOM_CLEAR) begin
                            count_reg <= '0;
                        end
                    end
                end
                HASH: begin
                    match_reg <= match_reg & bits_reg[hash_idx];
                    step_reg  <= step_reg + StepWidth'(1);
                    if (op_reg == BLOOM_INSERT) begin
                        bits_reg[hash_idx] <= 1'b1;
                        if (last_hash && (count_reg != '1)) begin
                            count_reg <= count_reg + CntWidth'(1);
                        end
                    end
                end
                CLEAR: begin
                    bits_reg[word_base +: WordWidth] <= '0;
                    step_reg <= step_reg + StepWidth'(1);
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o = (state_reg == IDLE);
    assign busy_o      = (state_reg != IDLE);
    assign rsp_valid_o = (state_reg == RESP);
    assign rsp_match_o = rsp_valid_o & match_reg;
    assign rsp_err_o   = rsp_valid_o & err_reg;
    assign count_o     = count_reg;

endmodule

// File: tb/tb_ibex_bloom_filter.sv
// Directed self-checking bench for ibex_bloom_filter with hand-computed hash
// indices, latencies, counter values and handshake behaviour.
module tb_ibex_bloom_filter;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_key;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_match;
    logic        rsp_err;
    logic        busy;
    logic [15:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] OP_INSERT = 2'b00;
    localparam logic [1:0] OP_CHECK  = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_BAD    = 2'b11;

    ibex_bloom_filter dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_key_i   (req_key),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_match_o (rsp_match),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .count_o     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Issues one request and checks latency (cycles from accept to rsp_valid) and payload.
    task automatic do_req(input string tag, input logic [1:0] op, input logic [31:0] key,
                          input int exp_lat, input logic exp_match, input logic exp_err);
        int lat;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_match"}, 32'(rsp_match), 32'(exp_match));
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        if (rsp_ready) begin
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_key   = '0;
        rsp_ready = 1'b1;
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_match", 32'(rsp_match), 32'd0);
        check("idle_err", 32'(rsp_err), 32'd0);

        // Key 0 hashes to index 0 three times.
        do_req("chk0_empty", OP_CHECK, 32'h0, 4, 1'b0, 1'b0);
        check("cnt_initial", 32'(count), 32'd0);
        do_req("ins0_first", OP_INSERT, 32'h0, 4, 1'b0, 1'b0);
        check("cnt_after_ins0", 32'(count), 32'd1);
        do_req("chk0_set", OP_CHECK, 32'h0, 4, 1'b1, 1'b0);
        do_req("ins0_again", OP_INSERT, 32'h0, 4, 1'b1, 1'b0);
        check("cnt_after_ins0b", 32'(count), 32'd2);

        // 0x12345678 -> indices F6, 7A, F8.
        do_req("ins_1234", OP_INSERT, 32'h12345678, 4, 1'b0, 1'b0);
        check("cnt_after_1234", 32'(count), 32'd3);
        do_req("chk_1234", OP_CHECK, 32'h12345678, 4, 1'b1, 1'b0);
        do_req("ins_2000", OP_INSERT, 32'h20000000, 4, 1'b0, 1'b0);
        do_req("clear", OP_CLEAR, 32'h0, 9, 1'b0, 1'b0);
        check("cnt_after_clear", 32'(count), 32'd0);
        do_req("chk_1234_clr", OP_CHECK, 32'h12345678, 4, 1'b0, 1'b0);
        do_req("chk0_clr", OP_CHECK, 32'h0, 4, 1'b0, 1'b0);
        do_req("chk_2000_clr", OP_CHECK, 32'h20000000, 4, 1'b0, 1'b0);

        // Key 1 -> {9E,85,C2}; key 2 -> {3C,0B,85}; 0x40000000 -> {40,C0,40};
        // 0xC0000000 -> {C0,40,C0} is covered by 0x40000000 without being inserted.
        do_req("ins_k1", OP_INSERT, 32'h1, 4, 1'b0, 1'b0);
        do_req("ins_k2", OP_INSERT, 32'h2, 4, 1'b0, 1'b0);
        do_req("chk_k1", OP_CHECK, 32'h1, 4, 1'b1, 1'b0);
        do_req("chk_k2", OP_CHECK, 32'h2, 4, 1'b1, 1'b0);
        do_req("chk_c0_pre", OP_CHECK, 32'hC0000000, 4, 1'b0, 1'b0);
        do_req("ins_40", OP_INSERT, 32'h40000000, 4, 1'b0, 1'b0);
        do_req("chk_c0_alias", OP_CHECK, 32'hC0000000, 4, 1'b1, 1'b0);
        do_req("chk_01000000", OP_CHECK, 32'h01000000, 4, 1'b0, 1'b0);
        check("cnt_three", 32'(count), 32'd3);

        do_req("illegal", OP_BAD, 32'h1, 1, 1'b0, 1'b1);
        check("cnt_illegal", 32'(count), 32'd3);
        do_req("chk_k1_ill", OP_CHECK, 32'h1, 4, 1'b1, 1'b0);

        // Response back-pressure.
        rsp_ready = 1'b0;
        do_req("hold", OP_CHECK, 32'h2, 4, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("hold%0d_match", i), 32'(rsp_match), 32'd1);
            check($sformatf("hold%0d_err", i), 32'(rsp_err), 32'd0);
            check($sformatf("hold%0d_ready", i), 32'(req_ready), 32'd0);
            check($sformatf("hold%0d_busy", i), 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("release_valid", 32'(rsp_valid), 32'd0);
        check("release_busy", 32'(busy), 32'd0);
        check("release_ready", 32'(req_ready), 32'd1);

        // Reset during the third CLEAR sweep cycle; key 1 lives in words 4 and 6.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_CLEAR;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("sweep_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_match", 32'(rsp_match), 32'd0);
        check("midrst_err", 32'(rsp_err), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req("chk_k1_rst", OP_CHECK, 32'h1, 4, 1'b0, 1'b0);
        do_req("ins_k1_rst", OP_INSERT, 32'h1, 4, 1'b0, 1'b0);
        check("cnt_post_rst", 32'(count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
